riscv_mc_controller: RTL and testbench

- Multicycle control FSM for the RV32I datapath.
- Sequences fetch, decode, execute, memory and writeback over a shared ALU and a single memory port.
- Drives every enable and mux select in the datapath, including `immsrc[2:0]` for the sign-extension unit.
- Waits on a memory ready handshake and latches an illegal-instruction trap.

---
 rtl/riscv_mc_controller.sv | 276 +++++++++++++++++++++++++++
 tb/tb_riscv_mc_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mc_controller.sv
// riscv_mc_controller
// Multicycle control FSM for an RV32I datapath. It sequences fetch, decode,
// execute, memory and writeback over one shared ALU and one memory port, and
// drives every enable and mux select in the datapath.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   op, funct3            instruction register fields
//   zero, lt, ltu         ALU flags for the current cycle's a-b
//   mem_ready             memory access completes this cycle
//   memread, memwrite     memory request, held until mem_ready
//   adrsrc                memory address select (0 PC, 1 ALUOut)
//   irwrite, pcwrite,
//   regwrite              register write enables
//   alusrca               ALU A select (00 PC, 01 OldPC, 10 rs1)
//   alusrcb               ALU B select (00 rs2, 01 immext, 10 constant 4)
//   aluop                 ALU class (00 add, 01 compare/sub, 10 funct decode)
//   resultsrc             result select (00 ALUOut, 01 rdata, 10 ALU, 11 imm)
//   immsrc                immediate format (000 I, 001 S, 010 B, 011 J,
//                         100 U, 101 shift uimm)
//   illegal               sticky illegal-instruction trap flag
//   instr_done            one-cycle retire pulse
//   state_dbg             current state encoding
//
// state    | meaning
// ---------+-------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE   | ALUOut <= OldPC+imm (branch/jal target)
// MEMADR   | ALUOut <= rs1+imm (load/store address)
// MEMREAD  | read data memory at ALUOut
// MEMWB    | rd <= read data
// MEMWRITE | write data memory at ALUOut
// EXECR    | ALUOut <= rs1 op rs2
// EXECI    | ALUOut <= rs1 op imm
// ALUWB    | rd <= ALUOut
// BRANCH   | compare rs1/rs2, PC <= ALUOut when taken
// JAL      | PC <= ALUOut, ALUOut <= OldPC+4 (link)
// JALR     | ALUOut <= rs1+imm, then reuse JAL
// LUI      | rd <= immext
// AUIPC    | ALUOut <= OldPC+imm
// TRAP     | illegal instruction, parked until reset

module riscv_mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       memread,
  output logic       memwrite,
  output logic       adrsrc,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] resultsrc,
  output logic [2:0] immsrc,
  output logic       illegal,
  output logic       instr_done,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_t state;
  state_t state_n;
  logic   illegal_q;
  logic   taken;
  logic   branch_bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_n;
      illegal_q <= illegal_q | (state_n == S_TRAP);
    end
  end

  // Branch condition; funct3 010/011 are not valid branch encodings.
  always_comb begin
    taken      = 1'b0;
    branch_bad = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: branch_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_n    = state;
    memread    = 1'b0;
    memwrite   = 1'b0;
    adrsrc     = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    resultsrc  = 2'b00;
    immsrc     = 3'b000;
    instr_done = 1'b0;

    case (op)
      OP_STORE:         immsrc = 3'b001;
      OP_BRANCH:        immsrc = 3'b010;
      OP_JAL:           immsrc = 3'b011;
      OP_LUI, OP_AUIPC: immsrc = 3'b100;
      OP_I:             immsrc = (funct3[1:0] == 2'b01) ? 3'b101 : 3'b000;
      default:          immsrc = 3'b000;
    endcase

    case (state)
      S_FETCH: begin
        memread   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        if (mem_ready) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_n = S_MEMADR;
          OP_R:              state_n = S_EXECR;
          OP_I:              state_n = S_EXECI;
          OP_BRANCH:         state_n = S_BRANCH;
          OP_JAL:            state_n = S_JAL;
          OP_JALR:           state_n = S_JALR;
          OP_LUI:            state_n = S_LUI;
          OP_AUIPC:          state_n = S_AUIPC;
          default:           state_n = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        state_n = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        memread = 1'b1;
        adrsrc  = 1'b1;
        if (mem_ready) state_n = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc = 2'b01;
        regwrite  = 1'b1;
        state_n   = S_FETCH;
      end
      S_MEMWRITE: begin
        memwrite = 1'b1;
        adrsrc   = 1'b1;
        if (mem_ready) state_n = S_FETCH;
      end
      S_EXECR: begin
        alusrca = 2'b10;
        aluop   = 2'b10;
        state_n = S_ALUWB;
      end
      S_EXECI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = 2'b10;
        state_n = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        state_n  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca = 2'b10;
        aluop   = 2'b01;
        if (branch_bad) begin
          state_n = S_TRAP;
        end else begin
          pcwrite = taken;
          state_n = S_FETCH;
        end
      end
      S_JAL: begin
        // PC takes the target held in ALUOut while the ALU forms OldPC+4.
        alusrca = 2'b01;
        alusrcb = 2'b10;
        pcwrite = 1'b1;
        state_n = S_ALUWB;
      end
      S_JALR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        state_n = S_JAL;
      end
      S_LUI: begin
        resultsrc = 2'b11;
        regwrite  = 1'b1;
        state_n   = S_FETCH;
      end
      S_AUIPC: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        state_n = S_ALUWB;
      end
      S_TRAP: begin
        state_n = S_TRAP;
      end
      default: begin
        state_n = S_TRAP;
      end
    endcase

    instr_done = (state != S_FETCH) && (state_n == S_FETCH);

    // Reset is asynchronous, so every output must go quiet in the same
    // cycle it rises, not only after the state register clears.
    if (reset) begin
      state_n    = S_FETCH;
      memread    = 1'b0;
      memwrite   = 1'b0;
      adrsrc     = 1'b0;
      irwrite    = 1'b0;
      pcwrite    = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 2'b00;
      alusrcb    = 2'b00;
      aluop      = 2'b00;
      resultsrc  = 2'b00;
      immsrc     = 3'b000;
      instr_done = 1'b0;
    end
  end

  assign illegal   = illegal_q & ~reset;
  assign state_dbg = reset ? 4'd0 : state;

endmodule

// File: tb/tb_riscv_mc_controller.sv
module tb_riscv_mc_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'b0;
  logic [2:0] funct3 = 3'b0;
  logic       zero = 1'b1;
  logic       lt = 1'b0;
  logic       ltu = 1'b0;
  logic       mem_ready = 1'b1;
  logic       memread, memwrite, adrsrc, irwrite, pcwrite, regwrite;
  logic [1:0] alusrca, alusrcb, aluop, resultsrc;
  logic [2:0] immsrc;
  logic       illegal, instr_done;
  logic [3:0] state_dbg;

  int total  = 0;
  int passed = 0;

  riscv_mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .memread(memread), .memwrite(memwrite), .adrsrc(adrsrc),
    .irwrite(irwrite), .pcwrite(pcwrite), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
    .resultsrc(resultsrc), .immsrc(immsrc), .illegal(illegal),
    .instr_done(instr_done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]      op;
    logic [2:0]      f3;
    logic [2:0]      imm;
    logic [2:0]      n;
    logic [4:0][3:0] seq;   // seq[i] = expected state in cycle i
    logic [4:0]      pcw;   // bit i = expected pcwrite in cycle i
    logic [4:0]      rw;
    logic [4:0]      mr;
    logic [4:0]      mw;
  } vec_t;

  vec_t vecs [15];

  // lw with 3 FETCH waits and 2 MEMREAD waits
  logic [3:0] ws_state [10] = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 4};
  logic [9:0] ws_ready = 10'b01_0000_1000;  // bit i = mem_ready in cycle i
  logic [9:0] ws_mr    = 10'b01_1100_1111;
  logic [9:0] ws_adr   = 10'b01_1100_0000;
  logic [9:0] ws_ir    = 10'b00_0000_1000;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{7'b0110011, 3'b000, 3'b000, 3'd4, {4'd0, 4'd8, 4'd6, 4'd1, 4'd0},  5'b00001, 5'b01000, 5'b00001, 5'b00000};
    vecs[1]  = '{7'b0010011, 3'b000, 3'b000, 3'd4, {4'd0, 4'd8, 4'd7, 4'd1, 4'd0},  5'b00001, 5'b01000, 5'b00001, 5'b00000};
    vecs[2]  = '{7'b0010011, 3'b101, 3'b101, 3'd4, {4'd0, 4'd8, 4'd7, 4'd1, 4'd0},  5'b00001, 5'b01000, 5'b00001, 5'b00000};
    vecs[3]  = '{7'b0000011, 3'b010, 3'b000, 3'd5, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0},  5'b00001, 5'b10000, 5'b01001, 5'b00000};
    vecs[4]  = '{7'b0100011, 3'b010, 3'b001, 3'd4, {4'd0, 4'd5, 4'd2, 4'd1, 4'd0},  5'b00001, 5'b00000, 5'b00001, 5'b01000};
    vecs[5]  = '{7'b1100011, 3'b000, 3'b010, 3'd3, {4'd0, 4'd0, 4'd9, 4'd1, 4'd0},  5'b00101, 5'b00000, 5'b00001, 5'b00000};
    vecs[6]  = '{7'b1100011, 3'b001, 3'b010, 3'd3, {4'd0, 4'd0, 4'd9, 4'd1, 4'd0},  5'b00001, 5'b00000, 5'b00001, 5'b00000};
    vecs[7]  = '{7'b1100011, 3'b100, 3'b010, 3'd3, {4'd0, 4'd0, 4'd9, 4'd1, 4'd0},  5'b00001, 5'b00000, 5'b00001, 5'b00000};
    vecs[8]  = '{7'b1100011, 3'b101, 3'b010, 3'd3, {4'd0, 4'd0, 4'd9, 4'd1, 4'd0},  5'b00101, 5'b00000, 5'b00001, 5'b00000};
    vecs[9]  = '{7'b1100011, 3'b110, 3'b010, 3'd3, {4'd0, 4'd0, 4'd9, 4'd1, 4'd0},  5'b00001, 5'b00000, 5'b00001, 5'b00000};
    vecs[10] = '{7'b1100011, 3'b111, 3'b010, 3'd3, {4'd0, 4'd0, 4'd9, 4'd1, 4'd0},  5'b00101, 5'b00000, 5'b00001, 5'b00000};
    vecs[11] = '{7'b1101111, 3'b000, 3'b011, 3'd4, {4'd0, 4'd8, 4'd10, 4'd1, 4'd0}, 5'b00101, 5'b01000, 5'b00001, 5'b00000};
    vecs[12] = '{7'b1100111, 3'b000, 3'b000, 3'd5, {4'd8, 4'd10, 4'd11, 4'd1, 4'd0}, 5'b01001, 5'b10000, 5'b00001, 5'b00000};
    vecs[13] = '{7'b0110111, 3'b000, 3'b100, 3'd3, {4'd0, 4'd0, 4'd12, 4'd1, 4'd0}, 5'b00001, 5'b00100, 5'b00001, 5'b00000};
    vecs[14] = '{7'b0010111, 3'b000, 3'b100, 3'd4, {4'd0, 4'd8, 4'd13, 4'd1, 4'd0}, 5'b00001, 5'b01000, 5'b00001, 5'b00000};

    // Reset state
    #1;
    check("rst state_dbg", state_dbg, 0);
    check("rst illegal", illegal, 0);
    check("rst enables", {memread, memwrite, irwrite, pcwrite, regwrite, instr_done}, 0);
    check("rst selects", {adrsrc, alusrca, alusrcb, aluop, resultsrc, immsrc}, 0);

    // Zero-wait instruction table, flags (zero,lt,ltu) = (1,0,0)
    for (int k = 0; k < 15; k++) begin
      op = vecs[k].op;
      funct3 = vecs[k].f3;
      do_reset();
      for (int i = 0; i < int'(vecs[k].n); i++) begin
        if (i > 0) @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check($sformatf("v%0d c%0d state", k, i), state_dbg, vecs[k].seq[i]);
        check($sformatf("v%0d c%0d done", k, i), instr_done, (i == int'(vecs[k].n) - 1) ? 1 : 0);
        check($sformatf("v%0d c%0d pcwrite", k, i), pcwrite, vecs[k].pcw[i]);
        check($sformatf("v%0d c%0d regwrite", k, i), regwrite, vecs[k].rw[i]);
        check($sformatf("v%0d c%0d memread", k, i), memread, vecs[k].mr[i]);
        check($sformatf("v%0d c%0d memwrite", k, i), memwrite, vecs[k].mw[i]);
        check($sformatf("v%0d c%0d irwrite", k, i), irwrite, (i == 0) ? 1 : 0);
        check($sformatf("v%0d c%0d immsrc", k, i), immsrc, vecs[k].imm);
      end
      @(negedge clk);
      #1;
      check($sformatf("v%0d back to fetch", k), state_dbg, 0);
      check($sformatf("v%0d illegal", k), illegal, 0);
    end

    // lw with wait states: 10 cycles, single irwrite pulse on first ready
    op = 7'b0000011;
    funct3 = 3'b010;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = ws_ready[i];
      #1;
      check($sformatf("ws c%0d state", i), state_dbg, ws_state[i]);
      check($sformatf("ws c%0d irwrite", i), irwrite, ws_ir[i]);
      check($sformatf("ws c%0d pcwrite", i), pcwrite, ws_ir[i]);
      check($sformatf("ws c%0d memread", i), memread, ws_mr[i]);
      check($sformatf("ws c%0d adrsrc", i), adrsrc, ws_adr[i]);
      check($sformatf("ws c%0d done", i), instr_done, (i == 9) ? 1 : 0);
    end
    @(negedge clk);
    #1;
    check("ws back to fetch", state_dbg, 0);

    // Reset while waiting in MEMWRITE
    op = 7'b0100011;
    funct3 = 3'b010;
    do_reset();
    mem_ready = 1'b1;
    #1;
    check("mw c0 state", state_dbg, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("mw wait state", state_dbg, 5);
    check("mw memwrite held", memwrite, 1);
    @(negedge clk);
    #1;
    check("mw still waiting", memwrite, 1);
    reset = 1'b1;
    #1;
    check("mw rst memwrite", memwrite, 0);
    check("mw rst state", state_dbg, 0);
    check("mw rst illegal", illegal, 0);
    check("mw rst enables", {pcwrite, regwrite, irwrite, adrsrc}, 0);
    @(posedge clk);
    #1;
    check("mw rst held", {state_dbg, memwrite}, 0);
    reset = 1'b0;
    mem_ready = 1'b1;

    // Branch with funct3 010 traps
    op = 7'b1100011;
    funct3 = 3'b010;
    do_reset();
    #1;
    check("bt c0 state", state_dbg, 0);
    @(negedge clk);
    #1;
    check("bt c1 state", state_dbg, 1);
    @(negedge clk);
    #1;
    check("bt c2 state", state_dbg, 9);
    check("bt c2 pcwrite", pcwrite, 0);
    check("bt c2 done", instr_done, 0);
    @(negedge clk);
    #1;
    check("bt trap state", state_dbg, 15);
    check("bt illegal", illegal, 1);

    // Illegal opcode, sticky, quiet for 20 cycles, cleared by reset
    op = 7'b0000000;
    funct3 = 3'b000;
    do_reset();
    #1;
    check("il c0 state", state_dbg, 0);
    check("il c0 illegal", illegal, 0);
    @(negedge clk);
    #1;
    check("il c1 state", state_dbg, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("il t%0d state", i), state_dbg, 15);
      check($sformatf("il t%0d illegal", i), illegal, 1);
      check($sformatf("il t%0d enables", i),
            {memread, memwrite, irwrite, pcwrite, regwrite, instr_done}, 0);
    end
    reset = 1'b1;
    #1;
    check("il rst illegal", illegal, 0);
    check("il rst state", state_dbg, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("il after rst memread", memread, 1);
    check("il after rst illegal", illegal, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
